// File: rtl/adder_rr_sched.sv
// Purpose: round-robin arbiter that shares one W-bit adder between NREQ requesters.
// Latency: grant cycle, one EXEC cycle, then the result is presented (3-cycle minimum issue interval).
// Backpressure: the result holds in DONE until res_ready; no new grant is issued meanwhile.
module adder_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic [1:0]        res_id,
  input  logic              res_ready,
  output logic [7:0]        served_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t       state;
  logic [1:0]   ptr;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [1:0]   id_q;

  logic         win_found;
  logic [1:0]   win_idx;
  logic [1:0]   cand;

  // Round-robin search starting at ptr; first requester with valid set wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant only while idle and out of reset; never depends on operands or res_ready.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !reset && win_found) begin
      req_ready = NREQ'(1) << win_idx;
    end
  end

  // Sequencer: capture operands on grant, add in EXEC, hold the result until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 2'd0;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_carry  <= 1'b0;
      res_id     <= 2'd0;
      served_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|(req_valid & req_ready)) begin
            a_q   <= req_a[win_idx*W +: W];
            b_q   <= req_b[win_idx*W +: W];
            id_q  <= win_idx;
            ptr   <= win_idx + 2'd1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          {res_carry, res_sum} <= {1'b0, a_q} + {1'b0, b_q};
          res_id    <= id_q;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            served_cnt <= served_cnt + 8'd1;
            state      <= S_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Purpose: directed self-checking bench for adder_rr_sched.
// Latency: checks grant, EXEC and DONE cycles explicitly at 3-cycle spacing.
// Backpressure: holds res_ready low in DONE and checks the result stays put.
module tb_adder_rr_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [3:0]  res_sum;
  logic        res_carry;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [7:0]  served_cnt;

  int tests;
  int fails;

  adder_rr_sched #(.NREQ(4), .W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .served_cnt (served_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = 16'hFFFF;
    req_b     = 16'hFFFF;
    res_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    tests++; if (served_cnt !== 8'd0) begin fails++; $display("FAIL reset_served got %0d want 0", served_cnt); end
    tests++; if ({res_carry, res_sum, res_id} !== 7'd0) begin fails++; $display("FAIL reset_result got c=%b s=%h id=%0d want 0", res_carry, res_sum, res_id); end
    reset     = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_a     = 16'h0003;
    req_b     = 16'h0004;
    res_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin fails++; $display("FAIL single_exec got rdy=%b vld=%b want 0000/0", req_ready, res_valid); end
    tick();
    @(negedge clk);
    tests++; if (res_valid !== 1'b1 || res_sum !== 4'd7 || res_carry !== 1'b0 || res_id !== 2'd0)
      begin fails++; $display("FAIL single_result got vld=%b s=%0d c=%b id=%0d want 1/7/0/0", res_valid, res_sum, res_carry, res_id); end
    tick();
    @(negedge clk);
    tests++; if (served_cnt !== 8'd1 || res_valid !== 1'b0) begin fails++; $display("FAIL single_served got cnt=%0d vld=%b want 1/0", served_cnt, res_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] ids [5];
    logic [3:0] sums [5];
    logic       cys [5];
    logic [3:0] oh;
    ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    sums = '{4'd4, 4'd7, 4'd2, 4'd0, 4'd4};
    cys  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    req_valid = 4'b1111;
    req_a     = 16'h9621;
    req_b     = 16'h7C53;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << ids[i];
      @(negedge clk);
      tests++; if (req_ready !== oh) begin fails++; $display("FAIL rr_grant[%0d] got %b want %b", i, req_ready, oh); end
      tick();
      @(negedge clk);
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rr_exec_ready[%0d] got %b want 0000", i, req_ready); end
      tick();
      @(negedge clk);
      tests++; if (res_valid !== 1'b1 || res_id !== ids[i] || res_sum !== sums[i] || res_carry !== cys[i])
        begin fails++; $display("FAIL rr_result[%0d] got vld=%b id=%0d s=%0d c=%b want 1/%0d/%0d/%b", i, res_valid, res_id, res_sum, res_carry, ids[i], sums[i], cys[i]); end
      tick();
    end
    @(negedge clk);
    tests++; if (served_cnt !== 8'd5) begin fails++; $display("FAIL rr_served got %0d want 5", served_cnt); end
    req_valid = 4'b0000;
  endtask

  task automatic test_fairness();
    logic [1:0] ids [3];
    logic [3:0] oh;
    ids = '{2'd3, 2'd0, 2'd3};
    do_reset();
    req_valid = 4'b0001;
    res_ready = 1'b1;
    tick();
    tick();
    tick();
    req_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      oh = 4'b0001 << ids[i];
      @(negedge clk);
      tests++; if (req_ready !== oh) begin fails++; $display("FAIL fair_grant[%0d] got %b want %b", i, req_ready, oh); end
      tick();
      tick();
      @(negedge clk);
      tests++; if (res_id !== ids[i]) begin fails++; $display("FAIL fair_id[%0d] got %0d want %0d", i, res_id, ids[i]); end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001;
    req_a     = 16'h000F;
    req_b     = 16'h0001;
    res_ready = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_grant got %b want 0001", req_ready); end
    tick();
    req_a = 16'hFFF5;
    req_b = 16'h3333;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (res_valid !== 1'b1 || res_sum !== 4'h0 || res_carry !== 1'b1 || req_ready !== 4'b0000 || served_cnt !== 8'd0)
        begin fails++; $display("FAIL bp_hold[%0d] got vld=%b s=%h c=%b rdy=%b cnt=%0d want 1/0/1/0000/0", i, res_valid, res_sum, res_carry, req_ready, served_cnt); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    tests++; if (served_cnt !== 8'd1 || res_valid !== 1'b0) begin fails++; $display("FAIL bp_release got cnt=%0d vld=%b want 1/0", served_cnt, res_valid); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_regrant got %b want 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_in_done();
    do_reset();
    req_valid = 4'b0001;
    req_a     = 16'h0002;
    req_b     = 16'h0003;
    res_ready = 1'b1;
    tick();
    tick();
    tick();
    res_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    tests++; if (res_valid !== 1'b1 || served_cnt !== 8'd1) begin fails++; $display("FAIL rid_pre got vld=%b cnt=%0d want 1/1", res_valid, served_cnt); end
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    @(negedge clk);
    tests++; if (res_valid !== 1'b0 || served_cnt !== 8'd0 || res_sum !== 4'd0) begin fails++; $display("FAIL rid_clear got vld=%b cnt=%0d s=%0d want 0/0/0", res_valid, served_cnt, res_sum); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rid_ptr got %b want 0001", req_ready); end
    tick();
    tick();
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rid_grant2 got %b want 0100", req_ready); end
    tick();
    tick();
    @(negedge clk);
    tests++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin fails++; $display("FAIL rid_id2 got vld=%b id=%0d want 1/2", res_valid, res_id); end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0001;
    res_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      tick();
      tick();
      tick();
    end
    @(negedge clk);
    tests++; if (served_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255 got %0d want 255", served_cnt); end
    tick();
    tick();
    tick();
    @(negedge clk);
    tests++; if (served_cnt !== 8'd0) begin fails++; $display("FAIL wrap_0 got %0d want 0", served_cnt); end
    req_valid = 4'b0000;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    res_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_reset_in_done();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
